// File: rtl/ee354_project_defs.sv
// Shared 7-segment definitions for the project: cathode table, capture FSM encodings.
// The display driver and the capture monitor both use hex_to_ssd, so the two cannot drift apart.
package ee354_project_defs;

    localparam int NUM_ANODES = 4;

    // Active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg}
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    localparam logic [1:0] ST_SCAN = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [6:0] hex_to_ssd(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ee354_project_seg_decode.sv
// Combinational inverse of hex_to_ssd: 7-bit active-low segment pattern -> {hit, hex}.
module ee354_project_seg_decode
    import ee354_project_defs::*;
(
    input  logic [6:0] seg_i,
    output logic       hit_o,
    output logic [3:0] hex_o
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        hit_o = 1'b0;
        hex_o = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == hex_to_ssd(4'(i))) begin
                hit_o = 1'b1;
                hex_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/ee354_project_ssd_capture.sv
// Receive-side monitor for the scanned 7-segment bus: recovers per-slot digits,
// rebuilds the displayed decimal value and flags scan, pattern and timeout faults.
module ee354_project_ssd_capture
    import ee354_project_defs::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int TIMEOUT       = 2**22
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] An,
    input  logic [7:0] Cath,
    input  logic       Err_Clr,
    output logic [3:0] Digit3,
    output logic [3:0] Digit2,
    output logic [3:0] Digit1,
    output logic [3:0] Digit0,
    output logic [3:0] Digit_Valid,
    output logic [9:0] Value,
    output logic       Frame_Done,
    output logic       Pattern_Err,
    output logic       Stale
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST   = IW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_MAX    = IW'(TIMEOUT);

    logic [15:0] sync1_q, sync2_q, prev_q;
    logic [SW-1:0] stable_q, stable_d;
    logic [IW-1:0] idle_q, idle_d;

    logic [NUM_ANODES-1:0][3:0] digit_q, digit_d;
    logic [NUM_ANODES-1:0]      valid_q, valid_d;
    logic [NUM_ANODES-1:0]      seen_q, seen_d;
    logic [2:0][3:0]            shadow_q, shadow_d;

    logic [9:0] acc_q, acc_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] state_q, state_d;
    logic [9:0] value_q, value_d;
    logic       frame_done_q, frame_done_d;
    logic       pattern_err_q, pattern_err_d;
    logic       stale_q, stale_d;

    logic [7:0] cap_an;
    logic [3:0] an_low;
    logic       capture_pt, upper_ok, slot_blank, slot_onehot;
    logic       bad_an, bad_seg, good_cap, err_set;
    logic [1:0] slot;
    logic       seg_hit;
    logic [3:0] seg_hex;
    logic [3:0] conv_digit;

    // The dwell is judged on the already-stable previous sample, so capture
    // sees the value that has been held for STABLE_CYCLES samples.
    assign cap_an      = prev_q[15:8];
    assign an_low      = ~cap_an[3:0];
    assign capture_pt  = (stable_q == STABLE_LAST);
    assign upper_ok    = (cap_an[7:4] == 4'hF);
    assign slot_blank  = upper_ok && (an_low == 4'd0);
    assign slot_onehot = upper_ok && $onehot(an_low);

    ee354_project_seg_decode u_seg_decode (
        .seg_i (prev_q[7:1]),
        .hit_o (seg_hit),
        .hex_o (seg_hex)
    );

    always_comb begin
        slot = 2'd0;
        for (int i = 0; i < NUM_ANODES; i++) begin
            if (an_low[i]) slot = 2'(i);
        end
    end

    assign bad_an   = capture_pt && !slot_blank && !slot_onehot;
    assign bad_seg  = capture_pt && slot_onehot && !seg_hit;
    assign good_cap = capture_pt && slot_onehot && seg_hit;

    always_comb begin
        if (sync2_q != prev_q) begin
            stable_d = '0;
        end else if (stable_q == STABLE_MAX) begin
            stable_d = stable_q;
        end else begin
            stable_d = stable_q + 1'b1;
        end
    end

    always_comb begin
        case (idx_q)
            2'd2:    conv_digit = shadow_q[2];
            2'd1:    conv_digit = shadow_q[1];
            default: conv_digit = shadow_q[0];
        endcase
    end

    always_comb begin
        digit_d      = digit_q;
        valid_d      = valid_q;
        seen_d       = seen_q;
        shadow_d     = shadow_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        state_d      = state_q;
        value_d      = value_q;
        frame_done_d = 1'b0;
        stale_d      = stale_q;
        idle_d       = idle_q;
        err_set      = bad_an || bad_seg;

        if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
        if (idle_q == IDLE_LAST && !good_cap) begin
            stale_d = 1'b1;
            valid_d = '0;
            seen_d  = '0;
        end

        case (state_q)
            ST_SCAN: begin
                if (seen_q == 4'hF) begin
                    seen_d   = '0;
                    shadow_d = digit_q[2:0];
                    if (digit_q[2] > 4'd9 || digit_q[1] > 4'd9 || digit_q[0] > 4'd9) begin
                        err_set = 1'b1;
                    end else begin
                        acc_d   = '0;
                        idx_d   = 2'd2;
                        state_d = ST_CONV;
                    end
                end
            end
            ST_CONV: begin
                acc_d = acc_q * 10'd10 + {6'd0, conv_digit};
                idx_d = idx_q - 1'b1;
                if (idx_q == 2'd0) state_d = ST_DONE;
            end
            ST_DONE: begin
                value_d      = acc_q;
                frame_done_d = 1'b1;
                state_d      = ST_SCAN;
            end
            default: state_d = ST_SCAN;
        endcase

        // Captures apply last so a slot landing on the snapshot cycle starts the next frame.
        if (good_cap) begin
            digit_d[slot] = seg_hex;
            valid_d[slot] = 1'b1;
            seen_d[slot]  = 1'b1;
            idle_d        = '0;
            stale_d       = 1'b0;
        end
        if (bad_seg) valid_d[slot] = 1'b0;

        pattern_err_d = err_set ? 1'b1 : (Err_Clr ? 1'b0 : pattern_err_q);
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // Digit registers are reset too: outputs must read 0 straight out of reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            prev_q        <= '0;
            stable_q      <= '0;
            idle_q        <= '0;
            digit_q       <= '0;
            valid_q       <= '0;
            seen_q        <= '0;
            shadow_q      <= '0;
            acc_q         <= '0;
            idx_q         <= '0;
            state_q       <= ST_SCAN;
            value_q       <= '0;
            frame_done_q  <= 1'b0;
            pattern_err_q <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            sync1_q       <= {An, Cath};
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            stable_q      <= stable_d;
            idle_q        <= idle_d;
            digit_q       <= digit_d;
            valid_q       <= valid_d;
            seen_q        <= seen_d;
            shadow_q      <= shadow_d;
            acc_q         <= acc_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            value_q       <= value_d;
            frame_done_q  <= frame_done_d;
            pattern_err_q <= pattern_err_d;
            stale_q       <= stale_d;
        end
    end

    assign Digit3      = digit_q[3];
    assign Digit2      = digit_q[2];
    assign Digit1      = digit_q[1];
    assign Digit0      = digit_q[0];
    assign Digit_Valid = valid_q;
    assign Value       = value_q;
    assign Frame_Done  = frame_done_q;
    assign Pattern_Err = pattern_err_q;
    assign Stale       = stale_q;

endmodule

// File: tb/tb_ee354_project_ssd_capture.sv
// Directed bench for the 7-segment capture monitor: scans frames, injects faults, checks outputs.
module tb_ee354_project_ssd_capture;

    localparam int TMO = 500;

    logic       Clk, Reset, Err_Clr;
    logic [7:0] An, Cath;
    logic [3:0] Digit3, Digit2, Digit1, Digit0, Digit_Valid;
    logic [9:0] Value;
    logic       Frame_Done, Pattern_Err, Stale;

    int tests = 0;
    int fails = 0;
    int fd_count = 0;

    ee354_project_ssd_capture #(.STABLE_CYCLES(16), .TIMEOUT(TMO)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .An          (An),
        .Cath        (Cath),
        .Err_Clr     (Err_Clr),
        .Digit3      (Digit3),
        .Digit2      (Digit2),
        .Digit1      (Digit1),
        .Digit0      (Digit0),
        .Digit_Valid (Digit_Valid),
        .Value       (Value),
        .Frame_Done  (Frame_Done),
        .Pattern_Err (Pattern_Err),
        .Stale       (Stale)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) if (Frame_Done === 1'b1) fd_count++;

    function automatic logic [6:0] ssd(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic show(input logic [3:0] an_lo, input logic [3:0] hex, input int cycles);
        An   = {4'hF, an_lo};
        Cath = {ssd(hex), 1'b1};
        repeat (cycles) @(negedge Clk);
    endtask

    task automatic blank(input int cycles);
        An   = 8'hFF;
        Cath = 8'hFF;
        repeat (cycles) @(negedge Clk);
    endtask

    task automatic pulse_clr();
        Err_Clr = 1'b1;
        @(negedge Clk);
        Err_Clr = 1'b0;
        @(negedge Clk);
    endtask

    task automatic wait_frame(input int exp_cnt, input string tag);
        for (int i = 0; i < 40 && fd_count < exp_cnt; i++) @(negedge Clk);
        check(tag, 16'(fd_count), 16'(exp_cnt));
    endtask

    initial begin
        Reset = 1'b0; Err_Clr = 1'b0; An = 8'hFF; Cath = 8'hFF;
        repeat (3) @(negedge Clk);
        check("rst_value", {6'd0, Value}, 16'd0);
        check("rst_flags", {12'd0, Frame_Done, Pattern_Err, Stale, 1'b0}, 16'd0);
        check("rst_valid", {12'd0, Digit_Valid}, 16'd0);
        Reset = 1'b1;
        blank(4);

        // 1: nominal frame 0,1,2,3
        show(4'b0111, 4'h0, 20);
        show(4'b1011, 4'h1, 20);
        show(4'b1101, 4'h2, 20);
        show(4'b1110, 4'h3, 20);
        blank(10);
        wait_frame(1, "t1_frame_done");
        check("t1_value", {6'd0, Value}, 16'd123);
        check("t1_valid", {12'd0, Digit_Valid}, 16'hF);
        check("t1_digits", {Digit3, Digit2, Digit1, Digit0}, 16'h0123);
        check("t1_err", {15'd0, Pattern_Err}, 16'd0);

        // 2: short dwell is ignored
        show(4'b0111, 4'h7, 5);
        blank(20);
        check("t2_digit3", {12'd0, Digit3}, 16'h0);
        check("t2_valid", {12'd0, Digit_Valid}, 16'hF);
        check("t2_err", {15'd0, Pattern_Err}, 16'd0);
        check("t2_no_frame", 16'(fd_count), 16'd1);

        // 3: unknown segment pattern on slot 0
        An = 8'hFE; Cath = 8'b10101011;
        repeat (20) @(negedge Clk);
        blank(2);
        check("t3_err", {15'd0, Pattern_Err}, 16'd1);
        check("t3_valid", {12'd0, Digit_Valid}, 16'hE);
        pulse_clr();
        check("t3_err_clr", {15'd0, Pattern_Err}, 16'd0);

        // 4: two anodes low, then a non-decimal digit in a full frame
        An = 8'hFC; Cath = {ssd(4'h5), 1'b1};
        repeat (20) @(negedge Clk);
        blank(2);
        check("t4_err_an", {15'd0, Pattern_Err}, 16'd1);
        check("t4_digits", {Digit3, Digit2, Digit1, Digit0}, 16'h0123);
        pulse_clr();
        check("t4_err_clr", {15'd0, Pattern_Err}, 16'd0);
        show(4'b0111, 4'h4, 20);
        An = 8'hFB; Cath = 8'b00010001;
        repeat (20) @(negedge Clk);
        show(4'b1101, 4'h5, 20);
        show(4'b1110, 4'h6, 20);
        blank(10);
        check("t4_err_hex", {15'd0, Pattern_Err}, 16'd1);
        check("t4_value_held", {6'd0, Value}, 16'd123);
        check("t4_no_frame", 16'(fd_count), 16'd1);
        check("t4_digits2", {Digit3, Digit2, Digit1, Digit0}, 16'h4A56);
        pulse_clr();

        // 5: timeout
        blank(TMO - 60);
        check("t5_not_stale", {15'd0, Stale}, 16'd0);
        blank(100);
        check("t5_stale", {15'd0, Stale}, 16'd1);
        check("t5_valid", {12'd0, Digit_Valid}, 16'h0);
        show(4'b0111, 4'h9, 20);
        check("t5_stale_clr", {15'd0, Stale}, 16'd0);
        check("t5_valid1", {12'd0, Digit_Valid}, 16'h8);
        show(4'b1011, 4'h4, 20);
        show(4'b1101, 4'h5, 20);
        show(4'b1110, 4'h6, 20);
        blank(10);
        wait_frame(2, "t5_frame_done");
        check("t5_value", {6'd0, Value}, 16'd456);
        check("t5_err", {15'd0, Pattern_Err}, 16'd0);

        // 6: reset mid-frame, then 2,2,5
        show(4'b0111, 4'h1, 20);
        show(4'b1011, 4'h7, 20);
        Reset = 1'b0;
        #1;
        check("t6_rst_value", {6'd0, Value}, 16'd0);
        check("t6_rst_digits", {Digit3, Digit2, Digit1, Digit0}, 16'h0000);
        check("t6_rst_flags", {12'd0, Digit_Valid}, 16'h0);
        check("t6_rst_bits", {13'd0, Frame_Done, Pattern_Err, Stale}, 16'd0);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        blank(4);
        show(4'b0111, 4'h8, 20);
        show(4'b1011, 4'h2, 20);
        show(4'b1101, 4'h2, 20);
        show(4'b1110, 4'h5, 20);
        blank(10);
        wait_frame(3, "t6_frame_done");
        check("t6_value", {6'd0, Value}, 16'd225);
        check("t6_valid", {12'd0, Digit_Valid}, 16'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
